// File: rtl/lbist_misr.sv
// lbist_misr: output response analyzer for the LBIST datapath.
// Compacts circuit-under-test responses into a multiple-input signature
// register and, once the pattern generator marks the final pattern, compares
// the signature with a golden value and reports pass/fail.
// The MISR uses the same external-XOR, shift-right convention as the pattern
// generator: the feedback bit enters at the MSB and the register shifts toward
// bit 0, with the response word XORed into every stage.

module lbist_misr #(
    parameter int                 BITS  = 4,
    parameter logic [BITS-1:0]    POLY  = 4'b1001,
    parameter logic [BITS-1:0]    SEED  = {BITS{1'b0}},
    parameter int                 CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [BITS-1:0]   resp,
    input  logic              end_in,
    input  logic [BITS-1:0]   golden,
    output logic [BITS-1:0]   signature,
    output logic [CNT_W-1:0]  pat_count,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CHECK = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Feedback bit: parity of the tapped MISR stages.
    function automatic logic misr_fb(input logic [BITS-1:0] sig);
        return ^(sig & POLY);
    endfunction

    // One compaction step: shift right with feedback into the MSB, then fold
    // in the response word.
    function automatic logic [BITS-1:0] misr_step(input logic [BITS-1:0] sig,
                                                  input logic [BITS-1:0] din);
        return {misr_fb(sig), sig[BITS-1:1]} ^ din;
    endfunction

    // Saturating increment so a very long run never wraps back to a small count.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == CNT_MAX) begin
            res = cnt;
        end else begin
            res = cnt + CNT_ONE;
        end
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [BITS-1:0]    sig_q,   sig_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               pass_q,  pass_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    // Next-state logic: run control, compaction, counting and the golden compare.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                // A response arriving with start is dropped: the run begins
                // from the seed on this edge.
                if (start) begin
                    state_d = ST_RUN;
                    sig_d   = SEED;
                    cnt_d   = CNT_ZERO;
                    pass_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // start is not looked at here; end_in only counts alongside
                // a valid response.
                if (resp_valid) begin
                    sig_d = misr_step(sig_q, resp);
                    cnt_d = cnt_inc(cnt_q);
                    if (end_in) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_CHECK: begin
                // Signature is final here; golden is sampled in this cycle only.
                pass_d  = (sig_q == golden);
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    sig_d   = SEED;
                    cnt_d   = CNT_ZERO;
                    pass_d  = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                sig_d   = SEED;
                cnt_d   = CNT_ZERO;
                pass_d  = 1'b0;
            end
        endcase
    end

    // Status flags follow the next state so they change on the same edge as it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_RUN:   busy_d = 1'b1;
            ST_CHECK: busy_d = 1'b1;
            ST_DONE:  done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial signature.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= CNT_ZERO;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign signature = sig_q;
    assign pat_count = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_lbist_misr.sv
// Testbench for lbist_misr: table of stimulus/expected records run through a
// scoreboard queue, plus hand-written reset and random-run sequences.

module tb_lbist_misr;

    localparam int BITS  = 4;
    localparam int CNT_W = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic              resp_valid;
    logic [BITS-1:0]   resp;
    logic              end_in;
    logic [BITS-1:0]   golden;
    logic [BITS-1:0]   signature;
    logic [CNT_W-1:0]  pat_count;
    logic              busy;
    logic              done;
    logic              pass;

    lbist_misr #(
        .BITS  (BITS),
        .POLY  (4'b1001),
        .SEED  (4'b0000),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .resp_valid (resp_valid),
        .resp       (resp),
        .end_in     (end_in),
        .golden     (golden),
        .signature  (signature),
        .pat_count  (pat_count),
        .busy       (busy),
        .done       (done),
        .pass       (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              start;
        logic              rv;
        logic [BITS-1:0]   resp;
        logic              end_in;
        logic [BITS-1:0]   golden;
        logic [BITS-1:0]   e_sig;
        logic [CNT_W-1:0]  e_cnt;
        logic              e_busy;
        logic              e_done;
        logic              e_pass;
    } vec_t;

    typedef struct {
        string             tag;
        logic [BITS-1:0]   sig;
        logic [CNT_W-1:0]  cnt;
        logic              busy;
        logic              done;
        logic              pass;
    } exp_t;

    vec_t tbl [17];
    exp_t sb_q [$];
    int   n_vec;
    int   n_miss;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s.%s: got %0h, required %0h", nm, fld, act, req);
        end
    endtask

    task automatic compare_now(input exp_t e);
        n_vec++;
        chk(e.tag, "signature", 32'(signature), 32'(e.sig));
        chk(e.tag, "pat_count", 32'(pat_count), 32'(e.cnt));
        chk(e.tag, "busy",      32'(busy),      32'(e.busy));
        chk(e.tag, "done",      32'(done),      32'(e.done));
        chk(e.tag, "pass",      32'(pass),      32'(e.pass));
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input string tag, input logic st, input logic rv,
                        input logic [BITS-1:0] rs, input logic ei,
                        input logic [BITS-1:0] gd, input exp_t e);
        exp_t got;
        start      = st;
        resp_valid = rv;
        resp       = rs;
        end_in     = ei;
        golden     = gd;
        e.tag      = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        compare_now(got);
    endtask

    task automatic run_vec(input int i);
        exp_t e;
        e.tag  = "";
        e.sig  = tbl[i].e_sig;
        e.cnt  = tbl[i].e_cnt;
        e.busy = tbl[i].e_busy;
        e.done = tbl[i].e_done;
        e.pass = tbl[i].e_pass;
        step($sformatf("tbl%0d", i), tbl[i].start, tbl[i].rv, tbl[i].resp,
             tbl[i].end_in, tbl[i].golden, e);
    endtask

    // Reference MISR step written straight from the algorithm description.
    function automatic logic [BITS-1:0] ref_step(input logic [BITS-1:0] s,
                                                 input logic [BITS-1:0] d);
        logic fb;
        fb = s[3] ^ s[0];
        return {fb, s[3], s[2], s[1]} ^ d;
    endfunction

    initial begin
        exp_t e;
        logic [BITS-1:0] msig;
        int   mcnt;

        n_vec  = 0;
        n_miss = 0;

        //              st   rv   resp     end  golden   sig      cnt    busy done pass
        tbl[0]  = '{1'b1,1'b0,4'b0000,1'b0,4'b1101, 4'b0000,16'd0, 1'b1,1'b0,1'b0}; // start
        tbl[1]  = '{1'b0,1'b1,4'b0001,1'b0,4'b1101, 4'b0001,16'd1, 1'b1,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b1,4'b0010,1'b0,4'b1101, 4'b1010,16'd2, 1'b1,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b1,4'b0000,1'b1,4'b1101, 4'b1101,16'd3, 1'b1,1'b0,1'b0}; // -> CHECK
        tbl[4]  = '{1'b0,1'b0,4'b0000,1'b0,4'b1101, 4'b1101,16'd3, 1'b0,1'b1,1'b1}; // DONE pass
        tbl[5]  = '{1'b0,1'b0,4'b0000,1'b0,4'b1101, 4'b1101,16'd3, 1'b0,1'b1,1'b1}; // hold
        tbl[6]  = '{1'b1,1'b1,4'b1111,1'b0,4'b1101, 4'b0000,16'd0, 1'b1,1'b0,1'b0}; // restart, resp dropped
        tbl[7]  = '{1'b1,1'b1,4'b0001,1'b0,4'b1101, 4'b0001,16'd1, 1'b1,1'b0,1'b0}; // start ignored in RUN
        tbl[8]  = '{1'b0,1'b0,4'b0110,1'b1,4'b1101, 4'b0001,16'd1, 1'b1,1'b0,1'b0}; // spurious end_in
        tbl[9]  = '{1'b0,1'b1,4'b0010,1'b0,4'b1101, 4'b1010,16'd2, 1'b1,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b0,4'b1111,1'b0,4'b1101, 4'b1010,16'd2, 1'b1,1'b0,1'b0}; // gap
        tbl[11] = '{1'b0,1'b1,4'b0000,1'b1,4'b1101, 4'b1101,16'd3, 1'b1,1'b0,1'b0}; // -> CHECK
        tbl[12] = '{1'b0,1'b1,4'b1111,1'b0,4'b1100, 4'b1101,16'd3, 1'b0,1'b1,1'b0}; // wrong golden
        tbl[13] = '{1'b0,1'b1,4'b0101,1'b1,4'b1101, 4'b1101,16'd3, 1'b0,1'b1,1'b0}; // DONE holds
        tbl[14] = '{1'b1,1'b0,4'b0000,1'b0,4'b1101, 4'b0000,16'd0, 1'b1,1'b0,1'b0}; // restart
        tbl[15] = '{1'b0,1'b1,4'b0001,1'b0,4'b1101, 4'b0001,16'd1, 1'b1,1'b0,1'b0};
        tbl[16] = '{1'b0,1'b1,4'b0010,1'b0,4'b1101, 4'b1010,16'd2, 1'b1,1'b0,1'b0};

        rst        = 1'b0;
        start      = 1'b0;
        resp_valid = 1'b0;
        resp       = 4'b0000;
        end_in     = 1'b0;
        golden     = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        e = '{"reset", 4'b0000, 16'd0, 1'b0, 1'b0, 1'b0};
        compare_now(e);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            run_vec(i);
        end

        // Asynchronous reset mid-run, away from any clock edge.
        start      = 1'b0;
        resp_valid = 1'b0;
        end_in     = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        e = '{"async_rst", 4'b0000, 16'd0, 1'b0, 1'b0, 1'b0};
        compare_now(e);
        @(posedge clk);
        #1;
        e = '{"rst_hold", 4'b0000, 16'd0, 1'b0, 1'b0, 1'b0};
        compare_now(e);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full rerun after reset must still pass.
        for (int i = 0; i < 6; i++) begin
            run_vec(i);
        end

        // Random run with gaps, expectations from the reference model.
        msig = 4'b0000;
        mcnt = 0;
        step("rnd_start", 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000,
             '{"", 4'b0000, 16'd0, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 30; k++) begin
            logic            rv;
            logic [BITS-1:0] d;
            rv = ($urandom_range(0, 3) != 0);
            d  = 4'($urandom_range(0, 15));
            if (rv) begin
                msig = ref_step(msig, d);
                mcnt++;
            end
            step($sformatf("rnd%0d", k), 1'b0, rv, d, (k == 29) && rv ? 1'b0 : 1'b0,
                 4'b0000, '{"", msig, 16'(mcnt), 1'b1, 1'b0, 1'b0});
        end
        msig = ref_step(msig, 4'b1011);
        mcnt++;
        step("rnd_last", 1'b0, 1'b1, 4'b1011, 1'b1, 4'b0000,
             '{"", msig, 16'(mcnt), 1'b1, 1'b0, 1'b0});
        step("rnd_check", 1'b0, 1'b0, 4'b0000, 1'b0, msig,
             '{"", msig, 16'(mcnt), 1'b0, 1'b1, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lbist_misr.md
# lbist_misr

Output response analyzer for the LBIST datapath. It compacts the circuit-under-test responses, applied by the random pattern generator, into a multiple-input signature register (MISR). When the generator signals end of pattern cycle, it compares the final signature against a golden value and reports pass/fail. It is the capture end of the pattern generator: same width, same external-XOR shift-right convention.

## Interface
- BITS, 4, width of the response bus and the MISR
- POLY, 4'b1001, feedback tap mask: bit i set means MISR bit i feeds the XOR
- SEED, 0, MISR value loaded on reset and on start
- CNT_W, 16, width of the pattern counter

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset: low forces reset state immediately, independent of clk
- start  input  1  begin a new compaction run; sampled only in IDLE or DONE
- resp_valid  input  1  resp is a valid response this cycle
- resp  input  BITS  circuit-under-test response word
- end_in  input  1  last pattern marker from the pattern generator; meaningful only with resp_valid
- golden  input  BITS  expected signature; sampled in CHECK
- signature  output  BITS  current MISR contents
- pat_count  output  CNT_W  number of responses compacted this run; saturates at all-ones
- busy  output  1  high in RUN and CHECK
- done  output  1  high in DONE
- pass  output  1  valid while done; 1 means signature == golden

## Operation
- States are IDLE, RUN, CHECK and DONE.
- Reset (rst low): state=IDLE, signature=SEED, pat_count=0, busy=0, done=0, pass=0. This applies at any point, including mid-RUN; the partial signature is discarded.
- IDLE: start=1 → RUN; signature<=SEED, pat_count<=0.
- RUN, on each cycle with resp_valid=1:
  - fb = XOR-reduce(POLY & signature)
  - signature <= {fb, signature[BITS-1:1]} ^ resp
  - pat_count <= pat_count+1, saturating
- RUN, other cases:
  - resp_valid=0: signature and pat_count hold.
  - resp_valid=1 and end_in=1: that response is compacted, then → CHECK.
  - end_in=1 with resp_valid=0: ignored.
  - start in RUN: ignored.
- CHECK: pass<=(signature==golden) → DONE. resp_valid is ignored; the signature holds.
- DONE: done=1, and signature, pass and pat_count hold. start=1 → RUN with signature<=SEED, pat_count<=0, pass<=0.
- start and resp_valid in the same IDLE/DONE cycle: only start acts; the response is not compacted.

## Timing
- Compaction has 1-cycle latency: signature reflects resp on the edge after it is presented.
- Final response with end_in is captured at edge N, and state=CHECK after N.
- At edge N+1, pass is registered and state=DONE, so done=1 and pass are valid from N+1.
- busy rises on the edge that accepts start and falls on edge N+1.
- Back-to-back responses are allowed, one per cycle; there is no backpressure.
- All outputs are registered; nothing is combinational from the inputs.

## Test plan
- Compaction sequence. Setup: BITS=4, POLY=1001, SEED=0, golden=1101. Stimulus: start, then resp 0001, 0010, 0000 (end_in on the third) on consecutive cycles. Required: signature goes 0001, 1010, 1101; pat_count=3; one cycle later done=1, pass=1.
- Wrong golden. Same stimulus with golden=1100 → done=1, pass=0, signature=1101.
- resp_valid gaps. Insert two idle cycles between each response → signature and pat_count hold during the gaps; final result identical to the first scenario.
- Reset mid-RUN. Pull rst low after the second response → signature=0000, pat_count=0, state IDLE, busy=0 immediately without waiting for clk. After reset is released, a full rerun gives pass=1.
- Restart from DONE. Assert start in DONE → pass and done clear, and signature=SEED on the next edge. A second run with the same responses gives pass=1. start asserted during RUN has no effect.
- Spurious end_in. end_in=1 with resp_valid=0 mid-run → stays in RUN; signature unchanged.
